ifu_fetch_queue: RTL and testbench
==================================

// Module: ifu_fetch_queue
// PURPOSE
//  Next-generation instruction fetch front end. Drives the I-cache lookup address and runs static next-PC prediction.
//  Buffers fetched instructions in a DEPTH-entry FIFO, which decouples cache hits from decode stalls.
//  Sits between the I-cache (combinational hit/inst lookup) and the decode stage (valid/ready).
//  Accepts jump and CSR/trap redirects, and holds a redirect until a pending cache refill completes.
// PARAMETERS
//  DEPTH      4             queue entries; power of two, >= 2
//  XLEN       32            PC and instruction width
//  RESET_PC   32'h30000000  first fetch address after reset
//  PRED_MODE  1             0: always pc+4; 1: backward B-type taken, JAL taken, else pc+4
// PORTS
//  clock          in   1               single clock; all state updates on posedge
//  reset          in   1               asynchronous, active-low reset
//  cache_addr     out  XLEN            lookup address (= fetch_pc)
//  cache_hit      in   1               cache_inst valid for cache_addr this cycle
//  cache_inst     in   32              instruction word at cache_addr
//  jump_flush     in   1               branch/jump mispredict redirect
//  jump_dnpc      in   XLEN            jump redirect target
//  cs_flush       in   1               CSR/trap redirect; has priority over jump_flush
//  cs_dnpc        in   XLEN            CSR redirect target
//  out_ready      in   1               decode accepts head entry
//  out_valid      out  1               head entry valid
//  out_pc         out  XLEN            head entry PC
//  out_inst       out  32              head entry instruction
//  out_pred_taken out  1               head entry was predicted taken
//  occupancy      out  $clog2(DEPTH+1) entries held
// BEHAVIOUR
//  Reset (async, reset==0):
//   - fetch_pc=RESET_PC; queue empty (rd_ptr=wr_ptr=0); pending_redirect=0.
//   - Outputs: out_valid=0, occupancy=0, out_pc/out_inst/out_pred_taken=0.
//   - Reset mid-refill discards all state; the first fetch after release is RESET_PC.
//  Signal definitions:
//   - flush = cs_flush | jump_flush.
//   - dnpc = cs_flush ? cs_dnpc : jump_dnpc.
//   - enq = cache_hit & ~flush & ~pending_redirect & (~full | deq).
//   - deq = out_valid & out_ready.
//  Prediction (on cache_inst; opcode = inst[6:2]):
//   - 11000 (B-type) with inst[31]=1: target = fetch_pc + imm_b, pred_taken=1.
//   - 11011 (JAL): target = fetch_pc + imm_j, pred_taken=1.
//   - Otherwise: target = fetch_pc + 4, pred_taken=0.
//   - PRED_MODE=0 forces pc+4 and pred_taken=0 for every instruction.
//   - Additions are XLEN bits and wrap modulo 2^XLEN.
//  Enqueue: on enq, entry {fetch_pc, cache_inst, pred_taken} is written at wr_ptr and fetch_pc <= target.
//  Hold: on cache_hit with the queue full and no deq, nothing is written and fetch_pc holds.
//  Cache miss: fetch_pc holds; cache_addr must stay stable until cache_hit.
//  Dequeue:
//   - out_* show the head entry registered, so latency from cache hit to out_valid is 1 cycle; no bypass.
//   - out_valid = ~empty & ~flush.
//   - deq advances rd_ptr.
//   - Full-with-deq allows a same-cycle enq; occupancy is unchanged.
//   - Pointers are log2(DEPTH)+1 bits; full/empty are decided by the wrap bit.
//  Redirect:
//   - Any flush empties the queue at the next edge; wr_ptr=rd_ptr, occupancy=0.
//   - With flush & cache_hit: fetch_pc <= dnpc and the hit data is dropped.
//   - With flush & ~cache_hit: pending_redirect <= 1 and target_r <= dnpc.
//   - A later flush while pending overwrites target_r with the new dnpc (cs priority applies).
//   - With pending_redirect & cache_hit: fetch_pc <= target_r (or dnpc if a flush arrives that cycle), pending_redirect <= 0, data dropped.
//   - While pending, enq is suppressed and out_valid=0 (the queue is already empty).
//  Simultaneous events: in a flush cycle, flush wins over enq and deq; out_valid is masked, so no deq occurs.
// TESTING
//  T1 reset, then always-hit cache returning NOPs, out_ready=1
//     -> cache_addr 0x30000000, +4 per cycle; out_valid 1 cycle after the first hit.
//  T2 out_ready=0 with always-hit, DEPTH=4
//     -> occupancy 1,2,3,4 then holds; cache_addr frozen at RESET_PC+16.
//     -> raising out_ready drains entries in PC order.
//  T3 inst 0xFE000EE3 (beq, offset -4) at 0x30000010, PRED_MODE=1
//     -> next cache_addr 0x3000000C, out_pred_taken=1.
//     -> with PRED_MODE=0: next cache_addr 0x30000014, out_pred_taken=0.
//  T4 jump_flush and cs_flush in the same cycle (dnpc 0x80000100 / 0x80000200) with hit
//     -> occupancy 0 next cycle; cache_addr 0x80000200.
//  T5 jump_flush with dnpc 0x80000040 during a 5-cycle miss, then cs_flush with dnpc 0x80000080 on cycle 3
//     -> cache_addr stable until hit, then 0x80000080; no entries enqueued from the stale line.
//  T6 full queue with out_ready=1 and continuous hits
//     -> one enq and one deq per cycle; occupancy stays DEPTH.
//     -> reset asserted mid-stream clears out_valid immediately (asynchronous).

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch front end: drives the I-cache lookup PC, predicts the next PC
// statically, and buffers fetched instructions for decode in a DEPTH-entry FIFO.
module ifu_fetch_queue #(
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h3000_0000),
    parameter int unsigned     PRED_MODE = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [XLEN-1:0]            cache_addr,
    input  logic                       cache_hit,
    input  logic [31:0]                cache_inst,
    input  logic                       jump_flush,
    input  logic [XLEN-1:0]            jump_dnpc,
    input  logic                       cs_flush,
    input  logic [XLEN-1:0]            cs_dnpc,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_inst,
    output logic                       out_pred_taken,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            pending_q, pending_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];
    logic [DEPTH-1:0] pt_mem_q;

    logic            flush, empty, full, deq, enq;
    logic [XLEN-1:0] dnpc;
    logic [XLEN-1:0] imm_b, imm_j, pred_target;
    logic            pred_taken;
    logic [AW-1:0]   head;

    assign flush = cs_flush | jump_flush;
    assign dnpc  = cs_flush ? cs_dnpc : jump_dnpc;
    assign empty = (wr_ptr_q == rd_ptr_q);
    // Same slot index with differing wrap bits means the writer lapped the reader.
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head  = rd_ptr_q[AW-1:0];

    assign out_valid      = ~empty & ~flush;
    assign deq            = out_valid & out_ready;
    assign enq            = cache_hit & ~flush & ~pending_q & (~full | deq);
    assign cache_addr     = fetch_pc_q;
    assign occupancy      = OW'(wr_ptr_q - rd_ptr_q);
    assign out_pc         = empty ? '0 : pc_mem_q[head];
    assign out_inst       = empty ? '0 : inst_mem_q[head];
    assign out_pred_taken = empty ? 1'b0 : pt_mem_q[head];

    assign imm_b = {{(XLEN-12){cache_inst[31]}}, cache_inst[7], cache_inst[30:25],
                    cache_inst[11:8], 1'b0};
    assign imm_j = {{(XLEN-20){cache_inst[31]}}, cache_inst[19:12], cache_inst[20],
                    cache_inst[30:21], 1'b0};

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = fetch_pc_q + XLEN'(4);
        if (PRED_MODE != 0) begin
            if (cache_inst[6:2] == 5'b11000 && cache_inst[31]) begin
                pred_taken  = 1'b1;
                pred_target = fetch_pc_q + imm_b;
            end else if (cache_inst[6:2] == 5'b11011) begin
                pred_taken  = 1'b1;
                pred_target = fetch_pc_q + imm_j;
            end
        end
    end

    // A redirect that arrives on a miss is parked until the refill returns a hit.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        pending_d  = pending_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (flush) begin
            wr_ptr_d = rd_ptr_q;
            if (cache_hit) begin
                fetch_pc_d = dnpc;
                pending_d  = 1'b0;
            end else begin
                pending_d = 1'b1;
                target_d  = dnpc;
            end
        end else if (pending_q) begin
            if (cache_hit) begin
                fetch_pc_d = target_q;
                pending_d  = 1'b0;
            end
        end else begin
            if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
            if (enq) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                fetch_pc_d = pred_target;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            target_q   <= '0;
            pending_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            pending_q  <= pending_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            pc_mem_q[wr_ptr_q[AW-1:0]]   <= fetch_pc_q;
            inst_mem_q[wr_ptr_q[AW-1:0]] <= cache_inst;
            pt_mem_q[wr_ptr_q[AW-1:0]]   <= pred_taken;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: directed fetch/redirect scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_ifu_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h3000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] BEQ_BACK = 32'hFE00_0EE3;

    logic        clock, reset;
    logic        cache_hit, jump_flush, cs_flush, out_ready;
    logic [31:0] cache_inst, jump_dnpc, cs_dnpc;
    logic [31:0] cache_addr, out_pc, out_inst;
    logic        out_valid, out_pred_taken;
    logic [2:0]  occupancy;
    logic [31:0] addr1, pc1, inst1;
    logic        valid1, pt1;
    logic [2:0]  occ1;

    ifu_fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(RESET_PC), .PRED_MODE(1)) dut (
        .clock(clock), .reset(reset), .cache_addr(cache_addr), .cache_hit(cache_hit),
        .cache_inst(cache_inst), .jump_flush(jump_flush), .jump_dnpc(jump_dnpc),
        .cs_flush(cs_flush), .cs_dnpc(cs_dnpc), .out_ready(out_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_pred_taken(out_pred_taken), .occupancy(occupancy)
    );

    ifu_fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(RESET_PC), .PRED_MODE(0)) dut_np (
        .clock(clock), .reset(reset), .cache_addr(addr1), .cache_hit(cache_hit),
        .cache_inst(cache_inst), .jump_flush(jump_flush), .jump_dnpc(jump_dnpc),
        .cs_flush(cs_flush), .cs_dnpc(cs_dnpc), .out_ready(out_ready),
        .out_valid(valid1), .out_pc(pc1), .out_inst(inst1),
        .out_pred_taken(pt1), .occupancy(occ1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          pt;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc, m_tgt;
    bit          m_pend;
    int          checks = 0;
    int          errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Next PC from the prediction rules, offsets summed as plain integers.
    function automatic logic [31:0] pred_next(input logic [31:0] pc, input logic [31:0] i,
                                              output bit tk);
        int off;
        tk  = 1'b0;
        off = 4;
        if (i[6:2] == 5'b11000 && i[31]) begin
            off = -4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            tk  = 1'b1;
        end else if (i[6:2] == 5'b11011) begin
            off = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                  + int'(i[30:21]) * 2;
            tk  = 1'b1;
        end
        return pc + 32'(off);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: r = NOP;
            1: begin r[6:0] = 7'b1100011; r[31] = 1'b1; end
            2: r[6:0] = 7'b1100011;
            3: r[6:0] = 7'b1101111;
            default: ;
        endcase
        return r;
    endfunction

    task automatic set_in(input bit hit, input logic [31:0] inst, input bit rdy);
        cache_hit  = hit;
        cache_inst = inst;
        out_ready  = rdy;
        jump_flush = 1'b0;
        cs_flush   = 1'b0;
    endtask

    // Compare outputs mid-cycle, then advance the model on the clock edge.
    task automatic step();
        bit          fl, dq, room, tk;
        logic [31:0] dn, nx;
        ent_t        e;
        @(negedge clock);
        fl = cs_flush | jump_flush;
        check_eq("cache_addr", 64'(cache_addr), 64'(m_pc));
        check_eq("occupancy", 64'(occupancy), 64'(mq.size()));
        check_eq("out_valid", 64'(out_valid), 64'(mq.size() > 0 && !fl));
        if (mq.size() > 0 && !fl) begin
            check_eq("out_pc", 64'(out_pc), 64'(mq[0].pc));
            check_eq("out_inst", 64'(out_inst), 64'(mq[0].inst));
            check_eq("out_pred_taken", 64'(out_pred_taken), 64'(mq[0].pt));
        end
        @(posedge clock);
        dn = cs_flush ? cs_dnpc : jump_dnpc;
        if (fl) begin
            mq.delete();
            if (cache_hit) begin
                m_pc   = dn;
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
                m_tgt  = dn;
            end
        end else if (m_pend) begin
            if (cache_hit) begin
                m_pc   = m_tgt;
                m_pend = 1'b0;
            end
        end else begin
            dq   = (mq.size() > 0) && out_ready;
            room = (mq.size() < DEPTH) || dq;
            if (dq) void'(mq.pop_front());
            if (cache_hit && room) begin
                nx     = pred_next(m_pc, cache_inst, tk);
                e.pc   = m_pc;
                e.inst = cache_inst;
                e.pt   = tk;
                mq.push_back(e);
                m_pc = nx;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_occupancy", 64'(occupancy), 64'd0);
        check_eq("rst_cache_addr", 64'(cache_addr), 64'(RESET_PC));
        check_eq("rst_out_pc", 64'(out_pc), 64'd0);
        check_eq("rst_out_inst", 64'(out_inst), 64'd0);
        check_eq("rst_out_pt", 64'(out_pred_taken), 64'd0);
        mq.delete();
        m_pc   = RESET_PC;
        m_tgt  = '0;
        m_pend = 1'b0;
        set_in(1'b0, NOP, 1'b0);
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        logic [31:0] r, a;
        reset     = 1'b1;
        jump_dnpc = '0;
        cs_dnpc   = '0;
        set_in(1'b0, NOP, 1'b0);
        @(posedge clock);
        #1;

        // T1: always-hit NOP stream, decode always ready
        do_reset();
        set_in(1'b1, NOP, 1'b1);
        repeat (3) step();
        check_eq("t1_addr", 64'(cache_addr), 64'h3000_000C);
        check_eq("t1_valid", 64'(out_valid), 64'd1);
        check_eq("t1_head_pc", 64'(out_pc), 64'h3000_0008);

        // T2: decode stalled fills the queue, then drains in order
        do_reset();
        set_in(1'b1, NOP, 1'b0);
        repeat (6) step();
        check_eq("t2_occ_full", 64'(occupancy), 64'd4);
        check_eq("t2_addr_frozen", 64'(cache_addr), 64'h3000_0010);
        set_in(1'b0, NOP, 1'b1);
        repeat (5) step();
        check_eq("t2_drained", 64'(occupancy), 64'd0);

        // T3: backward beq predicted taken (mode 1) / not taken (mode 0)
        do_reset();
        set_in(1'b1, NOP, 1'b1);
        repeat (4) step();
        cache_inst = BEQ_BACK;
        step();
        cache_inst = NOP;
        check_eq("t3_addr_pred", 64'(cache_addr), 64'h3000_000C);
        check_eq("t3_head_pc", 64'(out_pc), 64'h3000_0010);
        check_eq("t3_pred_taken", 64'(out_pred_taken), 64'd1);
        check_eq("t3_np_addr", 64'(addr1), 64'h3000_0014);
        check_eq("t3_np_head_pc", 64'(pc1), 64'h3000_0010);
        check_eq("t3_np_pred_taken", 64'(pt1), 64'd0);
        step();

        // T4: simultaneous jump and CSR redirect with a hit
        jump_flush = 1'b1; jump_dnpc = 32'h8000_0100;
        cs_flush   = 1'b1; cs_dnpc   = 32'h8000_0200;
        step();
        check_eq("t4_occ", 64'(occupancy), 64'd0);
        check_eq("t4_addr", 64'(cache_addr), 64'h8000_0200);
        set_in(1'b0, NOP, 1'b1);

        // T5: redirects parked across a 5-cycle miss, later CSR one wins
        jump_flush = 1'b1; jump_dnpc = 32'h8000_0040;
        step();
        jump_flush = 1'b0;
        step();
        cs_flush = 1'b1; cs_dnpc = 32'h8000_0080;
        step();
        cs_flush = 1'b0;
        repeat (2) step();
        check_eq("t5_addr_stable", 64'(cache_addr), 64'h8000_0200);
        cache_hit = 1'b1;
        step();
        check_eq("t5_addr_redirect", 64'(cache_addr), 64'h8000_0080);
        check_eq("t5_stale_dropped", 64'(occupancy), 64'd0);
        step();
        check_eq("t5_first_enq", 64'(out_pc), 64'h8000_0080);

        // T6: full queue streaming one in / one out, then async reset mid-stream
        do_reset();
        set_in(1'b1, NOP, 1'b0);
        repeat (4) step();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("t6_occ_steady", 64'(occupancy), 64'd4);
        end
        check_eq("t6_valid_before_rst", 64'(out_valid), 64'd1);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cache_hit  = ($urandom_range(0, 9) < 7);
            cache_inst = rand_inst();
            out_ready  = ($urandom_range(0, 3) != 0);
            jump_flush = ($urandom_range(0, 19) == 0);
            cs_flush   = ($urandom_range(0, 24) == 0);
            r = $urandom;
            a = r & 32'hFFFF_FFFC;
            jump_dnpc = a;
            r = $urandom;
            a = r & 32'hFFFF_FFFC;
            cs_dnpc = a;
            step();
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
